// File: rtl/lighthouse_pkg.sv
// Lighthouse collector shared types.
// Sensor word width, default sizes and the FIFO entry layout.
package lighthouse_pkg;

  localparam int SENSOR_W        = 32;
  localparam int DEF_NUM_SENSORS = 8;
  localparam int DEF_FIFO_DEPTH  = 16;
  localparam int MAX_ID_W        = 5;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [SENSOR_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/lighthouse_fifo.sv
// First-word-fall-through FIFO for collected sensor entries.
// The head entry is visible combinationally whenever the FIFO is non-empty.
module lighthouse_fifo
  import lighthouse_pkg::*;
#(
  parameter  int DEPTH = DEF_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_level == LVL_W'(DEPTH));
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Storage write; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/lighthouse_collector.sv
// Collects per-channel sensor words into one FWFT output FIFO.
// Each channel has a one-entry holding register; a round-robin arbiter drains them.
module lighthouse_collector
  import lighthouse_pkg::*;
#(
  parameter  int NUM_SENSORS = DEF_NUM_SENSORS,
  parameter  int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  localparam int ID_W  = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SENSOR_W*NUM_SENSORS-1:0] sensor_data_in,
  input  logic [NUM_SENSORS-1:0]       data_ready_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SENSOR_W-1:0]          out_data,
  output logic [ID_W-1:0]              out_id,
  output logic [LVL_W-1:0]             fifo_level,
  output logic [NUM_SENSORS-1:0]       overrun,
  input  logic                         clear_overrun
);

  logic [NUM_SENSORS-1:0] r_pending;
  logic [SENSOR_W-1:0]    r_hold [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] r_overrun;
  logic [ID_W-1:0]        r_last;

  logic                   w_gnt_vld;
  logic [ID_W-1:0]        w_gnt_idx;
  logic [NUM_SENSORS-1:0] w_gnt;
  logic                   w_full;
  logic                   w_empty;
  entry_t                 w_push_entry;
  entry_t                 w_head;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int j;
    j         = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (!w_full) begin
      for (int k = 0; k < NUM_SENSORS; k++) begin
        j = int'(r_last) + 1 + k;
        if (j >= NUM_SENSORS) j = j - NUM_SENSORS;
        if (!w_gnt_vld && r_pending[ID_W'(j)]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = ID_W'(j);
        end
      end
    end
  end

  assign w_gnt = w_gnt_vld ? (NUM_SENSORS'(1) << w_gnt_idx) : '0;

  assign w_push_entry.id   = MAX_ID_W'(w_gnt_idx);
  assign w_push_entry.data = r_hold[w_gnt_idx];

  // Holding words load on every strobe; a same-cycle grant reads the old word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (data_ready_in[i] && !reset)
        r_hold[i] <= sensor_data_in[SENSOR_W*i +: SENSOR_W];
    end
  end

  // Pending flags and sticky overrun; a new set beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        if (data_ready_in[i])
          r_pending[i] <= 1'b1;
        else if (w_gnt[i])
          r_pending[i] <= 1'b0;
        if (data_ready_in[i] && r_pending[i] && !w_gnt[i])
          r_overrun[i] <= 1'b1;
        else if (clear_overrun)
          r_overrun[i] <= 1'b0;
      end
    end
  end

  // Last grant moves only on a grant; reset gives channel 0 first turn.
  always_ff @(posedge clk) begin
    if (reset)
      r_last <= ID_W'(NUM_SENSORS - 1);
    else if (w_gnt_vld)
      r_last <= w_gnt_idx;
  end

  lighthouse_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_gnt_vld),
    .push_data (w_push_entry),
    .pop       (out_ready),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (fifo_level)
  );

  assign out_valid = ~w_empty;
  assign out_data  = w_head.data;
  assign out_id    = w_head.id[ID_W-1:0];
  assign overrun   = r_overrun;

endmodule
